// File: rtl/controller_packet_tx.sv
// Game-controller packetiser: snapshots buttons/joystick and streams a 5-byte
// packet (header, buttons, X, Y, checksum) into UART_TX on a timer or on request.
module controller_packet_tx #(
    parameter logic [7:0] c_HEADER          = 8'hA5,
    parameter int         c_INTERVAL_CYCLES = 500000
) (
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic [7:0] i_BUTTONS,
    input  logic [7:0] i_JOY_X,
    input  logic [7:0] i_JOY_Y,
    input  logic       i_SEND,
    input  logic       i_TX_ACTIVE,
    input  logic       i_TX_DONE,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_BYTE,
    output logic       o_BUSY,
    output logic       o_PKT_SENT,
    output logic [7:0] o_PKT_COUNT
);

    localparam int                 c_CNT_W    = (c_INTERVAL_CYCLES > 2) ? $clog2(c_INTERVAL_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_INTERVAL_CYCLES - 1);
    localparam logic [2:0]         c_LAST_IDX = 3'd4;

    typedef enum logic [2:0] {
        s_IDLE,
        s_LOAD,
        s_WAIT_IDLE,
        s_STROBE,
        s_WAIT_DONE
    } t_state;

    t_state             r_state;
    t_state             w_next_state;
    logic [c_CNT_W-1:0] r_interval_cnt;
    logic               r_pending;
    logic [2:0]         r_index;
    logic [7:0]         r_buttons;
    logic [7:0]         r_joy_x;
    logic [7:0]         r_joy_y;
    logic [7:0]         r_checksum;
    logic [7:0]         r_tx_byte;
    logic               r_pkt_sent;
    logic [7:0]         r_pkt_count;

    logic               w_interval_trig;
    logic               w_trigger;
    logic               w_start;
    logic [7:0]         w_cur_byte;

    assign w_interval_trig = (r_interval_cnt == c_CNT_LAST);
    assign w_trigger       = i_SEND | w_interval_trig;
    assign w_start         = (r_state == s_IDLE) && (r_pending || w_trigger);

    // NOTE: every variable written in always_comb gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            s_IDLE:      if (r_pending || w_trigger) w_next_state = s_LOAD;
            s_LOAD:      w_next_state = s_WAIT_IDLE;
            s_WAIT_IDLE: if (!i_TX_ACTIVE) w_next_state = s_STROBE;
            s_STROBE:    w_next_state = s_WAIT_DONE;
            s_WAIT_DONE: begin
                if (i_TX_DONE) begin
                    w_next_state = (r_index == c_LAST_IDX) ? s_IDLE : s_WAIT_IDLE;
                end
            end
            default:     w_next_state = s_IDLE;
        endcase
    end

    always_comb begin
        w_cur_byte = c_HEADER;
        case (r_index)
            3'd1:    w_cur_byte = r_buttons;
            3'd2:    w_cur_byte = r_joy_x;
            3'd3:    w_cur_byte = r_joy_y;
            3'd4:    w_cur_byte = r_checksum;
            default: w_cur_byte = c_HEADER;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so block ordering cannot change behaviour.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_state <= s_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_interval_cnt <= '0;
        end else if (w_interval_trig) begin
            r_interval_cnt <= '0;
        end else begin
            r_interval_cnt <= r_interval_cnt + c_CNT_W'(1);
        end
    end

    // A trigger consumed to leave IDLE is not re-queued; one arriving while a
    // pending request is being consumed keeps the flag set.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_pending <= 1'b0;
        end else if (w_start) begin
            r_pending <= r_pending & w_trigger;
        end else if (w_trigger) begin
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_index     <= '0;
            r_buttons   <= '0;
            r_joy_x     <= '0;
            r_joy_y     <= '0;
            r_checksum  <= '0;
            r_tx_byte   <= '0;
            r_pkt_sent  <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_pkt_sent <= 1'b0;
            case (r_state)
                s_LOAD: begin
                    r_buttons  <= i_BUTTONS;
                    r_joy_x    <= i_JOY_X;
                    r_joy_y    <= i_JOY_Y;
                    r_checksum <= c_HEADER ^ i_BUTTONS ^ i_JOY_X ^ i_JOY_Y;
                    r_index    <= '0;
                end
                s_WAIT_IDLE: begin
                    // Byte is registered one cycle ahead so it is valid with the strobe.
                    if (!i_TX_ACTIVE) r_tx_byte <= w_cur_byte;
                end
                s_WAIT_DONE: begin
                    if (i_TX_DONE) begin
                        if (r_index == c_LAST_IDX) begin
                            r_pkt_sent  <= 1'b1;
                            r_pkt_count <= r_pkt_count + 8'd1;
                        end else begin
                            r_index <= r_index + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_TX_DV     = (r_state == s_STROBE);
    assign o_TX_BYTE   = r_tx_byte;
    assign o_BUSY      = (r_state != s_IDLE);
    assign o_PKT_SENT  = r_pkt_sent;
    assign o_PKT_COUNT = r_pkt_count;

endmodule

// File: tb/tb_controller_packet_tx.sv
// Self-checking bench for controller_packet_tx with a behavioural UART_TX model
// and a short interval so periodic triggering and count wrap are reachable.
module tb_controller_packet_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] buttons;
    logic [7:0] joy_x;
    logic [7:0] joy_y;
    logic       send;
    logic       tx_active;
    logic       tx_done;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       busy;
    logic       pkt_sent;
    logic [7:0] pkt_count;

    always #5 clk = ~clk;

    controller_packet_tx #(
        .c_HEADER          (8'hA5),
        .c_INTERVAL_CYCLES (100)
    ) dut (
        .i_CLK       (clk),
        .i_RESET     (rst),
        .i_BUTTONS   (buttons),
        .i_JOY_X     (joy_x),
        .i_JOY_Y     (joy_y),
        .i_SEND      (send),
        .i_TX_ACTIVE (tx_active),
        .i_TX_DONE   (tx_done),
        .o_TX_DV     (tx_dv),
        .o_TX_BYTE   (tx_byte),
        .o_BUSY      (busy),
        .o_PKT_SENT  (pkt_sent),
        .o_PKT_COUNT (pkt_count)
    );

    int         n_pass   = 0;
    int         n_checks = 0;
    int         cyc      = 0;
    int         sent_cnt = 0;
    int         unstable = 0;
    int         tx_lat   = 2;
    int         m_cnt    = 0;
    bit         model_en = 1'b1;
    logic [7:0] last_byte;
    logic [7:0] bytes_q[$];
    int         strobe_q[$];

    typedef struct {
        logic [7:0] buttons;
        logic [7:0] joy_x;
        logic [7:0] joy_y;
        logic [7:0] exp_chk;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] qbyte(input int i);
        if (i < bytes_q.size()) return bytes_q[i];
        return 8'hxx;
    endfunction

    function automatic int qstrobe(input int i);
        if (i < strobe_q.size()) return strobe_q[i];
        return -1;
    endfunction

    // UART_TX model and monitors: act just after each rising edge.
    initial begin
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pkt_sent === 1'b1) sent_cnt++;
            if (model_en) begin
                if (tx_done) tx_done = 1'b0;
                if (m_cnt > 0) begin
                    if (tx_byte !== last_byte) unstable++;
                    m_cnt--;
                    if (m_cnt == 0) begin
                        tx_done   = 1'b1;
                        tx_active = 1'b0;
                    end
                end
            end
            if (tx_dv === 1'b1) begin
                bytes_q.push_back(tx_byte);
                strobe_q.push_back(cyc);
                last_byte = tx_byte;
                if (model_en) begin
                    m_cnt     = tx_lat;
                    tx_active = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        send      = 1'b0;
        tx_active = 1'b0;
        tx_done   = 1'b0;
        m_cnt     = 0;
        @(negedge clk);
        rst = 1'b0;
        bytes_q.delete();
        strobe_q.delete();
        sent_cnt = 0;
    endtask

    task automatic send_pulse(output int t);
        @(negedge clk);
        send = 1'b1;
        t    = cyc;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sent(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (sent_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_strobes(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (strobe_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t0;
        int bad;
        bit ok;

        vecs[0] = '{8'h81, 8'h40, 8'hC0, 8'hA4};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'hA5};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'h5A};
        vecs[3] = '{8'h5A, 8'hA5, 8'h3C, 8'h66};
        vecs[4] = '{8'h01, 8'h02, 8'h04, 8'hA2};
        vecs[5] = '{8'h12, 8'h34, 8'h56, 8'hD5};

        rst     = 1'b0;
        send    = 1'b0;
        buttons = 8'h00;
        joy_x   = 8'h00;
        joy_y   = 8'h00;

        // Reset state
        do_reset();
        check("reset busy", busy, 0);
        check("reset tx_dv", tx_dv, 0);
        check("reset tx_byte", tx_byte, 0);
        check("reset pkt_sent", pkt_sent, 0);
        check("reset pkt_count", pkt_count, 0);

        // Packet contents for each vector
        tx_lat = 2;
        for (int v = 0; v < 6; v++) begin
            do_reset();
            buttons = vecs[v].buttons;
            joy_x   = vecs[v].joy_x;
            joy_y   = vecs[v].joy_y;
            send_pulse(t);
            wait_sent(1, ok);
            check($sformatf("vec%0d sent", v), ok, 1);
            check($sformatf("vec%0d header", v), qbyte(0), 8'hA5);
            check($sformatf("vec%0d buttons", v), qbyte(1), vecs[v].buttons);
            check($sformatf("vec%0d joy_x", v), qbyte(2), vecs[v].joy_x);
            check($sformatf("vec%0d joy_y", v), qbyte(3), vecs[v].joy_y);
            check($sformatf("vec%0d checksum", v), qbyte(4), vecs[v].exp_chk);
            check($sformatf("vec%0d count", v), pkt_count, 1);
        end

        // Latency and inter-byte gap with done 10 cycles after each strobe
        do_reset();
        tx_lat  = 10;
        buttons = 8'h81;
        joy_x   = 8'h40;
        joy_y   = 8'hC0;
        send_pulse(t);
        wait_sent(1, ok);
        check("lat sent", ok, 1);
        wait_cycles(20);
        check("lat strobe count", strobe_q.size(), 5);
        check("lat header cycle", qstrobe(0), t + 3);
        for (int k = 1; k < 5; k++) begin
            check($sformatf("lat gap%0d", k), qstrobe(k) - qstrobe(k - 1), 12);
        end
        check("lat sent pulses", sent_cnt, 1);
        check("lat busy after", busy, 0);

        // Snapshot hold: inputs change after the header strobe
        do_reset();
        buttons = 8'h81;
        joy_x   = 8'h40;
        joy_y   = 8'hC0;
        send_pulse(t);
        wait_strobes(1, ok);
        check("snap header seen", ok, 1);
        buttons = 8'hFF;
        joy_x   = 8'h00;
        joy_y   = 8'hFF;
        wait_sent(1, ok);
        check("snap sent", ok, 1);
        check("snap buttons", qbyte(1), 8'h81);
        check("snap joy_x", qbyte(2), 8'h40);
        check("snap joy_y", qbyte(3), 8'hC0);
        check("snap checksum", qbyte(4), 8'hA4);
        check("snap byte held in idle", tx_byte, 8'hA4);

        // Coalescing: three requests during a packet give one more packet
        do_reset();
        tx_lat  = 2;
        buttons = 8'h12;
        joy_x   = 8'h34;
        joy_y   = 8'h56;
        send_pulse(t);
        wait_cycles(2);
        send_pulse(t);
        wait_cycles(3);
        send_pulse(t);
        wait_cycles(4);
        send_pulse(t);
        wait_sent(2, ok);
        check("coal second sent", ok, 1);
        wait_cycles(25);
        check("coal strobes", strobe_q.size(), 10);
        check("coal sent pulses", sent_cnt, 2);
        check("coal count", pkt_count, 2);
        check("coal 2nd header", qbyte(5), 8'hA5);
        check("coal 2nd checksum", qbyte(9), 8'hD5);

        // Reset mid-packet while the X byte is on the wire
        do_reset();
        tx_lat  = 10;
        buttons = 8'h81;
        joy_x   = 8'h40;
        joy_y   = 8'hC0;
        send_pulse(t);
        wait_strobes(3, ok);
        check("mid X strobe seen", ok, 1);
        model_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid busy", busy, 0);
        check("mid tx_dv", tx_dv, 0);
        check("mid tx_byte", tx_byte, 0);
        check("mid pkt_sent", pkt_sent, 0);
        check("mid pkt_count", pkt_count, 0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        wait_cycles(5);
        check("stray done no strobe", strobe_q.size(), 3);
        check("stray done busy", busy, 0);
        check("stray done no pkt", sent_cnt, 0);
        send_pulse(t);
        wait_cycles(8);
        check("wait active no strobe", strobe_q.size(), 3);
        check("wait active busy", busy, 1);
        @(negedge clk);
        tx_active = 1'b0;
        t0 = cyc;
        wait_strobes(4, ok);
        check("post reset header seen", ok, 1);
        check("post reset header cycle", qstrobe(3), t0 + 1);
        check("post reset header byte", qbyte(3), 8'hA5);

        // Periodic packets every 100 cycles and count wrap after 256
        do_reset();
        model_en = 1'b1;
        tx_lat   = 1;
        t0       = cyc;
        ok       = 1'b1;
        for (int p = 0; p < 256; p++) begin
            wait_sent(p + 1, ok);
            if (!ok) break;
            if (p == 254) check("periodic count 255", pkt_count, 255);
        end
        check("periodic all sent", ok, 1);
        check("periodic count wrap", pkt_count, 0);
        check("periodic first header", qstrobe(0), t0 + 102);
        check("periodic strobe total", strobe_q.size(), 1280);
        bad = 0;
        for (int k = 1; k < 256; k++) begin
            if (qstrobe(5 * k) - qstrobe(5 * k - 5) != 100) bad++;
        end
        check("periodic spacing errors", bad, 0);
        check("byte stable during wait_done", unstable, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/controller_packet_tx.md
Name: controller_packet_tx

Overview:
- Packetiser directly upstream of UART_TX in the game-controller link.
- Snapshots button and joystick state, frames it as a 5-byte packet: header, buttons, X, Y, checksum.
- Feeds the packet byte-by-byte into UART_TX using its i_TX_DV / o_TX_ACTIVE / o_TX_DONE handshake.
- Sends on a periodic timer and on an explicit send request.

Parameters:
c_HEADER, 8'hA5, first byte of every packet
c_INTERVAL_CYCLES, 500000, clock cycles between periodic triggers (10 ms at 50 MHz); minimum legal value 2

Ports:
i_CLK  in  1  system clock
i_RESET  in  1  synchronous, active-high reset
i_BUTTONS  in  8  button state, 1 = pressed
i_JOY_X  in  8  joystick X, unsigned
i_JOY_Y  in  8  joystick Y, unsigned
i_SEND  in  1  single-cycle request for an immediate packet
i_TX_ACTIVE  in  1  from UART_TX o_TX_ACTIVE
i_TX_DONE  in  1  from UART_TX o_TX_DONE, one-cycle pulse at end of stop bit
o_TX_DV  out  1  to UART_TX i_TX_DV, one-cycle strobe
o_TX_BYTE  out  8  to UART_TX i_PARALLEL_DATA
o_BUSY  out  1  high while a packet is in progress (any state except IDLE)
o_PKT_SENT  out  1  one-cycle pulse when the checksum byte's i_TX_DONE is accepted
o_PKT_COUNT  out  8  packets completed, wraps 255 -> 0

Behaviour:
- Reset: synchronous, active-high.
  - All outputs go to 0; state goes to IDLE.
  - Interval counter, pending flag and byte index clear.
  - Reset mid-packet abandons the packet with no o_PKT_SENT and no count increment.
- Interval counter:
  - Free-running 0 .. c_INTERVAL_CYCLES-1.
  - Generates a trigger in the cycle it equals c_INTERVAL_CYCLES-1, then wraps to 0.
  - Never stops, including while busy.
- Trigger = i_SEND OR interval trigger.
  - Any trigger sets the pending flag.
  - Multiple triggers while pending/busy coalesce into one pending packet.
  - A trigger in the same cycle the FSM leaves IDLE is not lost: pending stays set.
- FSM states:
  - IDLE: if pending, go to LOAD and clear pending.
  - LOAD: capture i_BUTTONS, i_JOY_X and i_JOY_Y into a snapshot.
    - Checksum = c_HEADER ^ BUTTONS ^ X ^ Y.
    - Byte index = 0.
    - Next state WAIT_IDLE.
    - Inputs changing after LOAD do not affect the packet.
  - WAIT_IDLE: stay while i_TX_ACTIVE = 1; otherwise go to STROBE.
  - STROBE: o_TX_DV = 1 for exactly this cycle.
    - o_TX_BYTE = byte[index] (0 header, 1 buttons, 2 X, 3 Y, 4 checksum).
    - Next state WAIT_DONE.
  - WAIT_DONE: o_TX_BYTE held stable; only here is i_TX_DONE accepted.
    - On i_TX_DONE with index < 4: index + 1, go to WAIT_IDLE.
    - On i_TX_DONE with index = 4: pulse o_PKT_SENT, o_PKT_COUNT + 1 mod 256, go to IDLE.
- i_TX_DONE seen in any state other than WAIT_DONE is ignored. This covers a stale done after reset.
- Latency: i_SEND high in cycle T with IDLE, nothing pending and i_TX_ACTIVE low:
  - LOAD in T+1, WAIT_IDLE in T+2, o_TX_DV in T+3.
  - Header strobe cycle = T+3.
- Inter-byte gap: the strobe for the next byte occurs 2 cycles after the accepted i_TX_DONE, provided i_TX_ACTIVE is low.
- A new packet's LOAD occurs the cycle after IDLE is entered, if pending.
- o_TX_BYTE keeps its last value in IDLE (0 after reset).

Test Plan:
- Reset, then i_BUTTONS=8'h81, i_JOY_X=8'h40, i_JOY_Y=8'hC0, pulse i_SEND, real UART_TX plus UART_RX, c_CYCLES_PER_BIT=434 -> RX receives A5, 81, 40, C0, A4 in order; o_PKT_SENT pulses once; o_PKT_COUNT=1.
- Latency: i_SEND at cycle T with a behavioural TX model -> o_TX_DV high in T+3 only.
  - Model returns i_TX_DONE 10 cycles after the strobe -> next strobe 2 cycles after each done.
  - Exactly 5 strobes total.
- Snapshot hold: change i_BUTTONS to 8'hFF after header strobe -> buttons byte is still 81 and checksum is still A4.
- Coalescing with c_INTERVAL_CYCLES=100: pulse i_SEND 3 times during a packet -> exactly one additional packet follows; o_PKT_COUNT advances by 2 total.
- Periodic/wrap with c_INTERVAL_CYCLES=100 and fast TX model, run 256 packets -> header strobes spaced exactly 100 cycles apart; o_PKT_COUNT wraps to 0.
- Reset mid-packet: assert i_RESET during the X byte while i_TX_ACTIVE=1 -> outputs 0 and IDLE.
  - Stray i_TX_DONE afterwards is ignored with no strobe.
  - Next i_SEND waits for i_TX_ACTIVE=0 before strobing the header A5.
